// File: rtl/irq_ack_sequencer.sv
// Back-end for the 27-channel interrupt priority encoder: qualifies stable request codes,
// queues them, and hands them to the CPU one at a time with EOI tracking.
module irq_ack_sequencer #(
  parameter int HOLD_CYC = 2,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_en,
  input  logic                     pa,
  input  logic                     pb,
  input  logic                     pc,
  input  logic [3:0]               chan,
  input  logic                     irq_ready,
  input  logic                     eoi,
  input  logic                     clr_ovf,
  output logic                     irq_valid,
  output logic [1:0]               irq_bus,
  output logic [3:0]               irq_chan,
  output logic                     in_svc,
  output logic [1:0]               svc_bus,
  output logic [3:0]               svc_chan,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW   = $clog2(DEPTH);
  localparam logic [3:0]      HOLD = 4'(HOLD_CYC);
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR1 = AW'(1);

  typedef enum logic [1:0] {IDLE, QUAL, ARMED} cap_state_t;

  cap_state_t     state, state_nx;
  logic [3:0]     stab, stab_nx;
  logic [5:0]     cur, cur_nx;
  logic [5:0]     smp;
  logic [1:0]     bus;
  logic           push, restart;

  logic [5:0]     mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic           empty, full, pop, do_push;

  always_comb begin
    if (pa)      bus = 2'd1;
    else if (pb) bus = 2'd2;
    else if (pc) bus = 2'd3;
    else         bus = 2'd0;
  end

  assign smp = {bus, chan};

  // A new code (from any state) restarts qualification; with HOLD_CYC = 1 it is pushed at once.
  always_comb begin
    state_nx = state;
    stab_nx  = stab;
    cur_nx   = cur;
    push     = 1'b0;
    restart  = 1'b0;
    if (!in_en || bus == 2'd0) begin
      state_nx = IDLE;
      stab_nx  = 4'd0;
    end else begin
      case (state)
        IDLE:  restart = 1'b1;
        QUAL: begin
          if (smp == cur) begin
            stab_nx = stab + 4'd1;
            if (stab_nx == HOLD) begin
              push     = 1'b1;
              state_nx = ARMED;
            end
          end else begin
            restart = 1'b1;
          end
        end
        ARMED: if (smp != cur) restart = 1'b1;
        default: restart = 1'b1;
      endcase
      if (restart) begin
        cur_nx  = smp;
        stab_nx = 4'd1;
        if (HOLD == 4'd1) begin
          push     = 1'b1;
          state_nx = ARMED;
        end else begin
          state_nx = QUAL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      stab  <= 4'd0;
      cur   <= 6'd0;
    end else begin
      state <= state_nx;
      stab  <= stab_nx;
      cur   <= cur_nx;
    end
  end

  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign irq_valid = !empty && !in_svc;
  assign pop       = irq_valid && irq_ready;
  assign do_push   = push && (!full || pop);
  assign irq_bus   = empty ? 2'd0 : mem[rd_ptr][5:4];
  assign irq_chan  = empty ? 4'd0 : mem[rd_ptr][3:0];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= smp;
  end

  // A pop frees a slot on the same edge, so a push into a full queue is only dropped without one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      in_svc   <= 1'b0;
      svc_bus  <= 2'd0;
      svc_chan <= 4'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR1;
      if (pop)     rd_ptr <= rd_ptr + PTR1;
      case ({do_push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)         overflow <= 1'b0;
      if (pop) begin
        in_svc   <= 1'b1;
        svc_bus  <= mem[rd_ptr][5:4];
        svc_chan <= mem[rd_ptr][3:0];
      end else if (eoi && in_svc) begin
        in_svc <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Scoreboard bench: a run-length reference model predicts queued codes; a monitor checks pops and status.
module tb_irq_ack_sequencer;

  localparam int HOLD_CYC = 2;
  localparam int DEPTH    = 4;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_en = 1'b0;
  logic          pa = 1'b0, pb = 1'b0, pc = 1'b0;
  logic [3:0]    chan = 4'd0;
  logic          irq_ready = 1'b0;
  logic          eoi = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          irq_valid;
  logic [1:0]    irq_bus;
  logic [3:0]    irq_chan;
  logic          in_svc;
  logic [1:0]    svc_bus;
  logic [3:0]    svc_chan;
  logic          overflow;
  logic [CW-1:0] count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [5:0] mq[$];
  logic [5:0] exp_q[$];
  bit         m_svc = 1'b0;
  logic [1:0] m_sbus = 2'd0;
  logic [3:0] m_schan = 4'd0;
  bit         m_ovf = 1'b0;
  int         run = 0;
  logic [5:0] last = 6'd0;
  bit         started = 1'b0;

  irq_ack_sequencer #(.HOLD_CYC(HOLD_CYC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .pa(pa), .pb(pb), .pc(pc), .chan(chan),
    .irq_ready(irq_ready), .eoi(eoi), .clr_ovf(clr_ovf), .irq_valid(irq_valid),
    .irq_bus(irq_bus), .irq_chan(irq_chan), .in_svc(in_svc), .svc_bus(svc_bus),
    .svc_chan(svc_chan), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // A code is captured when its run of identical enabled non-zero samples reaches HOLD_CYC.
  always @(posedge clk) begin
    logic [1:0] b;
    logic [5:0] s;
    logic [5:0] e;
    bit         p_pop, p_push;
    started = 1'b1;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_svc = 1'b0; m_sbus = 2'd0; m_schan = 4'd0; m_ovf = 1'b0;
      run = 0; last = 6'd0;
    end else begin
      b = pa ? 2'd1 : (pb ? 2'd2 : (pc ? 2'd3 : 2'd0));
      s = {b, chan};
      if (!in_en || b == 2'd0)          run = 0;
      else if (run > 0 && s == last)    run++;
      else                              run = 1;
      last   = s;
      p_push = (run == HOLD_CYC);
      p_pop  = (mq.size() > 0) && !m_svc && irq_ready;
      if (p_pop) begin
        e = mq.pop_front();
        m_svc = 1'b1; m_sbus = e[5:4]; m_schan = e[3:0];
      end else if (eoi && m_svc) begin
        m_svc = 1'b0;
      end
      if (p_push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(s);
          exp_q.push_back(s);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (clr_ovf) begin
        m_ovf = 1'b0;
      end
      if (p_push && mq.size() < DEPTH && clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    if (started) begin
      check_output("irq_valid", int'(irq_valid), int'(mq.size() > 0 && !m_svc));
      check_output("count", int'(count), mq.size());
      check_output("overflow", int'(overflow), int'(m_ovf));
      check_output("in_svc", int'(in_svc), int'(m_svc));
      check_output("svc_bus", int'(svc_bus), int'(m_sbus));
      check_output("svc_chan", int'(svc_chan), int'(m_schan));
      if (mq.size() == 0) begin
        check_output("empty_head", int'({irq_bus, irq_chan}), 0);
      end
      if (irq_valid && irq_ready && rst_n) begin
        if (exp_q.size() == 0) begin
          check_output("sb_underrun", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_output("pop_head", int'({irq_bus, irq_chan}), int'(e));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic b, input logic c,
                                input logic [3:0] ch, input int n);
    pa = a; pb = b; pc = c; chan = ch;
    tick(n);
  endtask

  task automatic drain();
    apply_stimulus(0, 0, 0, 4'd0, 1);
    irq_ready = 1'b1; eoi = 1'b1;
    tick(3 * DEPTH + 2);
    irq_ready = 1'b0; eoi = 1'b0;
    tick(1);
  endtask

  initial begin
    int hold;
    tick(2);
    rst_n = 1'b1; in_en = 1'b1;

    apply_stimulus(1, 0, 0, 4'd5, 4);
    apply_stimulus(0, 0, 0, 4'd0, 2);
    drain();

    apply_stimulus(0, 1, 0, 4'd3, 1);
    apply_stimulus(0, 1, 0, 4'd4, 2);
    apply_stimulus(0, 0, 0, 4'd0, 1);
    drain();

    apply_stimulus(1, 0, 1, 4'd7, 3);
    apply_stimulus(0, 0, 0, 4'd0, 1);
    apply_stimulus(1, 0, 1, 4'd7, 2);
    apply_stimulus(0, 0, 0, 4'd0, 2);
    irq_ready = 1'b1;
    tick(3);
    eoi = 1'b1; tick(1); eoi = 1'b0;
    tick(3);
    eoi = 1'b1; tick(1);
    tick(1); eoi = 1'b0;
    irq_ready = 1'b0;
    tick(2);

    for (int k = 0; k < 5; k++) apply_stimulus(0, 1, 0, 4'(k), 2);
    apply_stimulus(0, 0, 0, 4'd0, 2);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    apply_stimulus(0, 0, 1, 4'd9, 1);
    irq_ready = 1'b1; tick(1); irq_ready = 1'b0;
    apply_stimulus(0, 0, 0, 4'd0, 2);
    drain();

    apply_stimulus(1, 0, 0, 4'd2, 1);
    in_en = 1'b0; tick(1); in_en = 1'b1;
    apply_stimulus(0, 0, 0, 4'd0, 2);

    for (int k = 0; k < 4; k++) apply_stimulus(1, 0, 0, 4'(k + 8), 2);
    apply_stimulus(0, 0, 0, 4'd0, 1);
    irq_ready = 1'b1; tick(1); irq_ready = 1'b0;
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    tick(2);

    for (int i = 0; i < 600; i++) begin
      pa = 1'($urandom_range(0, 3) == 0);
      pb = 1'($urandom_range(0, 2) == 0);
      pc = 1'($urandom_range(0, 1) == 0);
      chan = 4'($urandom_range(0, 3));
      hold = $urandom_range(1, 4);
      for (int j = 0; j < hold; j++) begin
        irq_ready = 1'($urandom_range(0, 3) != 0);
        eoi       = 1'($urandom_range(0, 2) == 0);
        clr_ovf   = 1'($urandom_range(0, 9) == 0);
        in_en     = 1'($urandom_range(0, 15) != 0);
        rst_n     = 1'($urandom_range(0, 199) != 0);
        tick(1);
      end
    end
    rst_n = 1'b1; in_en = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ack_sequencer.md
# irq_ack_sequencer

Sequential back-end for the 27-channel interrupt priority encoder. Each cycle it samples the encoder's bus-request flags and 4-bit channel code, accepts a code only after it has been stable for a set number of cycles, and queues it. It presents queued interrupts to the CPU side over a valid/ready handshake and tracks a single in-service interrupt until end-of-interrupt (EOI).

## Interface
- `HOLD_CYC`, default 2: consecutive identical samples required before capture; legal values 1 to 15.
- `DEPTH`, default 4: queue entries; a power of two, at least 2.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_en`  in  1  capture enable.
- `pa`, `pb`, `pc`  in  1 each  request flags for bus A, bus B and bus C.
- `chan`  in  4  channel code from the encoder.
- `irq_ready`  in  1  consumer accepts the head entry.
- `eoi`  in  1  end of interrupt for the in-service entry.
- `clr_ovf`  in  1  clears `overflow`.
- `irq_valid`  out  1  head entry is available.
- `irq_bus`  out  2  head bus code: 1 = A, 2 = B, 3 = C.
- `irq_chan`  out  4  head channel code.
- `in_svc`  out  1  an interrupt is in service.
- `svc_bus`  out  2  bus code of the in-service interrupt.
- `svc_chan`  out  4  channel code of the in-service interrupt.
- `overflow`  out  1  sticky flag: a push was dropped.
- `count`  out  clog2(DEPTH)+1 bits  current queue occupancy.

## Operation
- **Bus code**: `pa` gives 1, else `pb` gives 2, else `pc` gives 3, else 0. The fixed priority is A > B > C. The sample is the 6-bit value {bus, `chan`}; bus code 0 means no request.
- **Capture FSM**, states IDLE, QUAL and ARMED, with a 4-bit stability counter `stab`:
  - IDLE: on a non-zero sample go to QUAL with `stab` = 1 and latch the sample as `cur`. If HOLD_CYC = 1, push on the same edge and go straight to ARMED.
  - QUAL:
    - Sample equals `cur`: `stab` increments. When it reaches HOLD_CYC, push `cur` and go to ARMED.
    - Sample is a different non-zero code: stay in QUAL, set `stab` = 1 and `cur` = sample.
    - Sample is zero: go to IDLE.
  - ARMED: the same code is never pushed twice in a row.
    - Same sample: stay in ARMED.
    - Different non-zero sample: go to QUAL with `stab` = 1.
    - Zero sample: go to IDLE.
  - `in_en` = 0 overrides every state: the FSM goes to IDLE and `stab` = 0. The queue and in-service state are not affected.
- **Queue**: DEPTH-entry FIFO of {bus, chan}. The head drives `irq_bus` and `irq_chan`; both read 0 when the queue is empty.
  - `irq_valid` = queue not empty AND NOT `in_svc`. This allows only one outstanding interrupt at a time.
  - Pop occurs when `irq_valid` and `irq_ready` are both high. The popped entry loads `svc_bus` and `svc_chan`, and `in_svc` goes to 1.
  - Push while full with no pop in the same cycle: the entry is dropped and `overflow` is set. Push and pop in the same cycle while full: both take effect and `count` is unchanged.
  - `overflow` is cleared by `clr_ovf` or by reset. If set and clear happen in the same cycle, set wins.
- **EOI**: `eoi` while `in_svc` = 1 clears `in_svc`; `svc_bus` and `svc_chan` keep their values. `eoi` while `in_svc` = 0 is ignored. Because `irq_valid` is low while in service, EOI and pop can never happen in the same cycle.
- **Reset**: all outputs are 0, the FSM is in IDLE, `stab` = 0, and the queue is empty. Reset asserted in the middle of an operation discards all queued and in-service state on that edge.

## Timing
- Inputs are sampled only on rising edges of `clk`; no input is used combinationally to produce an output.
- Capture latency: if a code is first sampled at edge E0, the push occurs at edge E(HOLD_CYC−1).
- `irq_valid` rises in the cycle after the push edge, provided the queue was empty and `in_svc` = 0.
- Pop and load of `in_svc` happen on the same edge; `irq_valid` drops immediately after it.
- After an EOI edge, `irq_valid` for the next queued entry is high in the following cycle.
- `count` reflects pushes and pops on the edge where they happen.

## Test plan
- **Reset then single capture**: hold `pa` = 1, `chan` = 5 for 4 cycles with `in_en` = 1 and HOLD_CYC = 2. Required: exactly one push. `irq_valid` goes high with `irq_bus` = 1, `irq_chan` = 5 one cycle after the second sample. `count` = 1.
- **Glitch filter**: sample sequence B/3, B/4, B/4. Required: the push holds {2, 4} only; code {2, 3} is never queued.
- **Priority and re-arm**: `pa` and `pc` both high, `chan` = 7, for 3 cycles. Then inputs go to zero for 1 cycle, then the same inputs return for 2 cycles. Required: two entries {1, 7}, {1, 7}; `count` = 2.
- **Handshake and EOI**: 2 entries queued, `irq_ready` held at 1. Required: the first pop sets `in_svc` = 1 and `irq_valid` = 0. The second entry is presented only in the cycle after `eoi`. An `eoi` pulse with `in_svc` = 0 changes nothing.
- **Overflow**: DEPTH = 4 and `irq_ready` = 0; push 5 distinct codes. Required: `count` = 4, `overflow` = 1, and the head is still the first code. A push and pop in the same cycle while full leaves `count` = 4 and does not set `overflow` again after `clr_ovf`.
- **Reset and enable mid-operation**:
  - Drop `in_en` during QUAL: no push, and `count` is unchanged.
  - Assert `rst_n` = 0 for one edge while `in_svc` = 1 and `count` = 3: every output reads 0 afterwards.
